// File: rtl/riscv_ctrl_fsm_if.sv
// Memory port bundle between the RV32I control FSM (master) and instruction/data memory (slave).
// Request/ready handshake; ready is only meaningful while o_MEM_REQ is high.
interface riscv_ctrl_fsm_if;
  logic [31:0] i_INSTR;
  logic        i_MEM_READY;
  logic        o_MEM_REQ;
  logic        o_MEM_WE;
  logic        o_ADDR_SEL;

  modport master (
    input  i_INSTR,
    input  i_MEM_READY,
    output o_MEM_REQ,
    output o_MEM_WE,
    output o_ADDR_SEL
  );

  modport slave (
    output i_INSTR,
    output i_MEM_READY,
    input  o_MEM_REQ,
    input  o_MEM_WE,
    input  o_ADDR_SEL
  );
endinterface

// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle RV32I control unit: owns PC/IR and sequences FETCH-DECODE-EXEC-MEM-WB.
// Optional feature macro RISCV_CTRL_TRAP_EN adds a sticky illegal-instruction TRAP state.
module riscv_ctrl_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  riscv_ctrl_fsm_if.master      mem,
  input  logic [31:0]           i_IMM,
  input  logic                  i_ALU_ZERO,
  output logic [31:0]           o_PC,
  output logic [31:0]           o_IR,
  output logic                  o_REG_WE,
  output logic [1:0]            o_WB_SEL,
  output logic [3:0]            o_ALU_OP,
  output logic                  o_ALU_SRC_B,
  output logic [2:0]            o_IMM_SEL,
  output logic                  o_TRAP
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
`ifdef RISCV_CTRL_TRAP_EN
    , S_TRAP = 3'd6
`endif
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, ir;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        supported;
  logic        br_taken;
  logic [31:0] pc_plus4, pc_plus_imm;

  logic        mem_req, mem_we, addr_sel;

  assign opcode      = ir[6:0];
  assign funct3      = ir[14:12];
  assign rd          = ir[11:7];
  assign pc_plus4    = pc + 32'd4;
  assign pc_plus_imm = pc + i_IMM;
  assign br_taken    = ((funct3 == 3'b000) && i_ALU_ZERO) ||
                       ((funct3 == 3'b001) && !i_ALU_ZERO);

  assign o_PC           = pc;
  assign o_IR           = ir;
  assign mem.o_MEM_REQ  = mem_req;
  assign mem.o_MEM_WE   = mem_we;
  assign mem.o_ADDR_SEL = addr_sel;

  function automatic logic is_supported(input logic [6:0] opc, input logic [2:0] f3);
    case (opc)
      OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_LUI: return 1'b1;
      OPC_BRANCH: return (f3 == 3'b000) || (f3 == 3'b001);
      default:    return 1'b0;
    endcase
  endfunction

  // IR[30] selects SUB only for register OP; SRA/SRAI honour it for both forms.
  function automatic logic [3:0] alu_op_of(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic b30);
    logic alt;
    if (opc == OPC_BRANCH) return 4'd1;
    if ((opc != OPC_OP) && (opc != OPC_OPIMM)) return 4'd0;
    alt = b30 && ((opc == OPC_OP) || (f3 == 3'b101));
    case (f3)
      3'b000:  return alt ? 4'd1 : 4'd0;
      3'b001:  return 4'd2;
      3'b010:  return 4'd3;
      3'b011:  return 4'd4;
      3'b100:  return 4'd5;
      3'b101:  return alt ? 4'd7 : 4'd6;
      3'b110:  return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic [2:0] imm_sel_of(input logic [6:0] opc);
    case (opc)
      OPC_STORE:  return 3'd1;
      OPC_BRANCH: return 3'd2;
      OPC_LUI:    return 3'd3;
      OPC_JAL:    return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] wb_sel_of(input logic [6:0] opc);
    case (opc)
      OPC_LOAD: return 2'b01;
      OPC_JAL:  return 2'b10;
      OPC_LUI:  return 2'b11;
      default:  return 2'b00;
    endcase
  endfunction

  assign supported = is_supported(opcode, funct3);

  always_ff @(posedge i_CLK) begin
    if (i_RST) state <= S_RST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:    state_nxt = S_FETCH;
      S_FETCH:  if (mem.i_MEM_READY) state_nxt = S_DECODE;
      S_DECODE: begin
        if (supported) state_nxt = S_EXEC;
`ifdef RISCV_CTRL_TRAP_EN
        else           state_nxt = S_TRAP;
`else
        else           state_nxt = S_FETCH;
`endif
      end
      S_EXEC: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: state_nxt = S_MEM;
          OPC_BRANCH:          state_nxt = S_FETCH;
          default:             state_nxt = S_WB;
        endcase
      end
      S_MEM:    if (mem.i_MEM_READY) state_nxt = (opcode == OPC_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
`ifdef RISCV_CTRL_TRAP_EN
      S_TRAP:   state_nxt = S_TRAP;
`endif
      default:  state_nxt = S_RST;
    endcase
  end

  // ALU/immediate controls stay valid through MEM and WB so the unregistered ALU result holds.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    o_REG_WE    = 1'b0;
    o_WB_SEL    = 2'b00;
    o_ALU_OP    = 4'd0;
    o_ALU_SRC_B = 1'b0;
    o_IMM_SEL   = 3'd0;
`ifdef RISCV_CTRL_TRAP_EN
    o_TRAP      = 1'b0;
`endif
    case (state)
      S_FETCH:  mem_req = 1'b1;
      S_DECODE: o_IMM_SEL = imm_sel_of(opcode);
      S_EXEC, S_MEM, S_WB: begin
        o_IMM_SEL   = imm_sel_of(opcode);
        o_ALU_OP    = alu_op_of(opcode, funct3, ir[30]);
        o_ALU_SRC_B = (opcode == OPC_OPIMM) || (opcode == OPC_LOAD) || (opcode == OPC_STORE);
        if (state == S_MEM) begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OPC_STORE);
        end
        if (state == S_WB) begin
          o_REG_WE = (rd != 5'd0);
          o_WB_SEL = wb_sel_of(opcode);
        end
      end
`ifdef RISCV_CTRL_TRAP_EN
      S_TRAP:   o_TRAP = 1'b1;
`endif
      default: ;
    endcase
  end

`ifndef RISCV_CTRL_TRAP_EN
  assign o_TRAP = 1'b0;
`endif

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      pc <= RESET_PC;
      ir <= 32'd0;
    end else begin
      case (state)
        S_FETCH:  if (mem.i_MEM_READY) ir <= mem.i_INSTR;
`ifndef RISCV_CTRL_TRAP_EN
        S_DECODE: if (!supported) pc <= pc_plus4;
`endif
        S_EXEC:   if (opcode == OPC_BRANCH) pc <= br_taken ? pc_plus_imm : pc_plus4;
        S_MEM:    if (mem.i_MEM_READY && (opcode == OPC_STORE)) pc <= pc_plus4;
        S_WB:     pc <= (opcode == OPC_JAL) ? pc_plus_imm : pc_plus4;
        default: ;
      endcase
    end
  end

endmodule
